ew_join_vec4: RTL

EW_JOIN_VEC4 -- requirements
Module: ew_join_vec4

---
 rtl/ew_pkg.sv | 22 ++
 rtl/ew_join_vec4_if.sv | 56 +++++
 rtl/ew_fifo_vec.sv | 93 +++++++++
 rtl/ew_join_vec4.sv | 118 +++++++++++
 4 files changed

// File: rtl/ew_pkg.sv
// ---------------------------------------------------------------------------
// ew_pkg -- shared definitions for the ew_* elementwise pipeline stages.
//
// Holds the default tile geometry (lanes per token, lane width), the
// lane/lane-vector typedefs that stages and benches share, and a helper
// that sizes FIFO occupancy counters.
// ---------------------------------------------------------------------------
package ew_pkg;

    localparam int EW_TILE_SIZE = 4;    // lanes per token
    localparam int EW_W         = 16;   // bits per lane

    typedef logic [EW_W-1:0]               lane_t;
    typedef lane_t [EW_TILE_SIZE-1:0]      lane_vec_t;

    // Occupancy counter width for a FIFO of the given depth. One extra bit
    // so that "full" (level == depth) is representable.
    function automatic int ew_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : ew_pkg

// File: rtl/ew_join_vec4_if.sv
// ---------------------------------------------------------------------------
// ew_join_vec4_if -- stream bundle for the lam/u join stage.
//
// Carries two input streams (lam, u), the joined output stream and the
// FIFO occupancy indicators.
//   master : environment side (drives input streams, accepts output)
//   slave  : join stage side
// Signals:
//   lam_valid/lam_ready/lam_vec  lam input stream (Q0.16 unsigned lanes)
//   u_valid/u_ready/u_vec        u input stream (Q8.8 signed lanes)
//   out_valid/out_ready          joined output handshake
//   lam_out/u_out                joined lanes, bit-exact copies of inputs
//   s_addr                       state slot for the current output token
//   lam_level/u_level            input FIFO occupancies
// ---------------------------------------------------------------------------
interface ew_join_vec4_if
    import ew_pkg::*;
#(
    parameter int TILE_SIZE  = EW_TILE_SIZE,
    parameter int W          = EW_W,
    parameter int S_ADDR_W   = 10,
    parameter int FIFO_DEPTH = 4
);

    localparam int LVL_W = ew_level_w(FIFO_DEPTH);

    logic                           lam_valid;
    logic                           lam_ready;
    logic [TILE_SIZE-1:0][W-1:0]    lam_vec;

    logic                           u_valid;
    logic                           u_ready;
    logic [TILE_SIZE-1:0][W-1:0]    u_vec;

    logic                           out_valid;
    logic                           out_ready;
    logic [TILE_SIZE-1:0][W-1:0]    lam_out;
    logic [TILE_SIZE-1:0][W-1:0]    u_out;
    logic [S_ADDR_W-1:0]            s_addr;

    logic [LVL_W-1:0]               lam_level;
    logic [LVL_W-1:0]               u_level;

    modport master (
        output lam_valid, lam_vec, u_valid, u_vec, out_ready,
        input  lam_ready, u_ready, out_valid, lam_out, u_out, s_addr,
               lam_level, u_level
    );

    modport slave (
        input  lam_valid, lam_vec, u_valid, u_vec, out_ready,
        output lam_ready, u_ready, out_valid, lam_out, u_out, s_addr,
               lam_level, u_level
    );

endinterface : ew_join_vec4_if

// File: rtl/ew_fifo_vec.sv
// ---------------------------------------------------------------------------
// ew_fifo_vec -- small synchronous FIFO with occupancy output and flush.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/level only)
//   flush        synchronous empty; overrides push and pop in that cycle
//   push, din    write request / data; ignored when full
//   pop          read request; ignored when empty
//   dout         head entry (valid while level != 0)
//   level        number of stored entries (0..DEPTH)
//   full         level == DEPTH; depends on state only, never on pop
//
// DEPTH must be a power of two so the pointers wrap for free. Storage is a
// plain register array read asynchronously: the head must be visible in
// the same cycle it becomes valid, and the array is only a few entries.
// ---------------------------------------------------------------------------
module ew_fifo_vec
    import ew_pkg::*;
#(
    parameter int WIDTH = EW_TILE_SIZE * EW_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [ew_level_w(DEPTH)-1:0] level,
    output logic                         full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = ew_level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            // Push and pop together leave the level untouched.
            if (do_push && !do_pop)
                level_d = level_q + 1'b1;
            else if (!do_push && do_pop)
                level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset; contents are only observed
    // through the pointers.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign level = level_q;

endmodule : ew_fifo_vec

// File: rtl/ew_join_vec4.sv
// ---------------------------------------------------------------------------
// ew_join_vec4 -- joins the lam and u token streams for the EMA update.
//
// Each input stream is buffered in its own ew_fifo_vec. A joined token is
// offered whenever both FIFOs hold data; on acceptance both FIFOs pop
// together and the state-slot counter (s_addr) advances, wrapping at
// S_DEPTH. The leading stream is back-pressured once its FIFO is full, so
// skew up to FIFO_DEPTH tokens is absorbed without loss.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (drops readies immediately)
//   clr    synchronous flush + address restart, overrides push/pop
//   bus    ew_join_vec4_if.slave stream bundle
// ---------------------------------------------------------------------------
module ew_join_vec4
    import ew_pkg::*;
#(
    parameter int TILE_SIZE  = EW_TILE_SIZE,
    parameter int W          = EW_W,
    parameter int S_ADDR_W   = 10,
    parameter int S_DEPTH    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    ew_join_vec4_if.slave bus
);

    localparam int VEC_W = TILE_SIZE * W;
    localparam int LVL_W = ew_level_w(FIFO_DEPTH);

    logic [VEC_W-1:0]    lam_din, lam_head;
    logic [VEC_W-1:0]    u_din,   u_head;
    logic [LVL_W-1:0]    lam_level, u_level;
    logic                lam_full,  u_full;
    logic                lam_ready, u_ready;
    logic                lam_push,  u_push;
    logic                out_valid;
    logic                fire;

    logic [S_ADDR_W-1:0] addr_q, addr_d;

    // Flatten lanes into FIFO words and back; lane order is preserved so
    // the output is a bit-exact copy of what was pushed.
    for (genvar gi = 0; gi < TILE_SIZE; gi++) begin : g_lane
        assign lam_din[gi*W +: W] = bus.lam_vec[gi];
        assign u_din[gi*W +: W]   = bus.u_vec[gi];
        assign bus.lam_out[gi]    = lam_head[gi*W +: W];
        assign bus.u_out[gi]      = u_head[gi*W +: W];
    end

    // Readiness looks only at the registered full flag (never at a
    // same-cycle pop). rst_n is included so ready drops the instant reset
    // asserts rather than waiting for the next edge.
    assign lam_ready = rst_n && !lam_full && !clr;
    assign u_ready   = rst_n && !u_full   && !clr;
    assign lam_push  = bus.lam_valid && lam_ready;
    assign u_push    = bus.u_valid   && u_ready;

    assign out_valid = (lam_level != '0) && (u_level != '0);
    // A clr cycle discards the pop; the FIFOs also gate it via flush.
    assign fire      = out_valid && bus.out_ready && !clr;

    ew_fifo_vec #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lam_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (lam_push),
        .din   (lam_din),
        .pop   (fire),
        .dout  (lam_head),
        .level (lam_level),
        .full  (lam_full)
    );

    ew_fifo_vec #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (u_push),
        .din   (u_din),
        .pop   (fire),
        .dout  (u_head),
        .level (u_level),
        .full  (u_full)
    );

    always_comb begin
        addr_d = addr_q;
        if (clr)
            addr_d = '0;
        else if (fire)
            addr_d = (addr_q == S_ADDR_W'(S_DEPTH - 1)) ? '0 : addr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_q <= '0;
        else
            addr_q <= addr_d;
    end

    assign bus.lam_ready = lam_ready;
    assign bus.u_ready   = u_ready;
    assign bus.out_valid = out_valid;
    assign bus.s_addr    = addr_q;
    assign bus.lam_level = lam_level;
    assign bus.u_level   = u_level;

endmodule : ew_join_vec4
